// File: rtl/sr_lut_weighted_accum.sv
// SR-LUT weighted accumulator: sums NTAP weight*value products per pixel into a
// saturating signed dividend plus an unsigned weight total for the round-div stage.
module sr_lut_weighted_accum #(
   parameter int NTAP      = 4,
   parameter int W_WIDTH   = 8,
   parameter int V_WIDTH   = 8,
   parameter int ACC_WIDTH = 32
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic        [W_WIDTH-1:0]              in_weight,
   input  logic signed [V_WIDTH-1:0]              in_value,
   input  logic                                   in_last,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic signed [ACC_WIDTH-1:0]            out_sum,
   output logic        [W_WIDTH+$clog2(NTAP)-1:0] out_wsum,
   output logic                                   out_sat,
   output logic                                   err_last
);
   localparam int CW  = $clog2(NTAP);
   localparam int WSW = W_WIDTH + CW;
   localparam int PW  = W_WIDTH + V_WIDTH + 1;
   localparam int EW  = ACC_WIDTH + 2;
   localparam logic [CW-1:0]         LAST_CNT = CW'(NTAP - 1);
   localparam logic signed [EW-1:0]  SMAX = {3'b000, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [EW-1:0]  SMIN = {3'b111, {(ACC_WIDTH-1){1'b0}}};

   function automatic logic ovf_f(input logic signed [EW-1:0] x);
      return (x > SMAX) || (x < SMIN);
   endfunction

   function automatic logic signed [ACC_WIDTH-1:0] sat_f(input logic signed [EW-1:0] x);
      if (x > SMAX) return SMAX[ACC_WIDTH-1:0];
      if (x < SMIN) return SMIN[ACC_WIDTH-1:0];
      return x[ACC_WIDTH-1:0];
   endfunction

   logic        [CW-1:0]        cnt_q, cnt_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d, sum_q, sum_d;
   logic        [WSW-1:0]       wacc_q, wacc_d, wsum_q, wsum_d;
   logic                        sat_q, sat_d, osat_q, osat_d;
   logic                        valid_q, valid_d, err_q, err_d;

   logic                        accept, first_tap, last_tap;
   logic signed [PW-1:0]        w_ext, v_ext, prod;
   logic signed [EW-1:0]        base_ext, prod_ext, sum_ext;
   logic signed [ACC_WIDTH-1:0] acc_next;
   logic        [WSW-1:0]       wacc_next;
   logic                        sat_next;

   assign in_ready  = !valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign first_tap = (cnt_q == '0);
   assign last_tap  = (cnt_q == LAST_CNT);

   // Weight is unsigned, so it is zero-extended before the signed multiply.
   assign w_ext    = $signed({{(V_WIDTH+1){1'b0}}, in_weight});
   assign v_ext    = {{(W_WIDTH+1){in_value[V_WIDTH-1]}}, in_value};
   assign prod     = w_ext * v_ext;
   assign prod_ext = {{(EW-PW){prod[PW-1]}}, prod};
   assign base_ext = first_tap ? '0 : {{2{acc_q[ACC_WIDTH-1]}}, acc_q};
   assign sum_ext  = base_ext + prod_ext;

   assign acc_next  = sat_f(sum_ext);
   assign sat_next  = (!first_tap && sat_q) || ovf_f(sum_ext);
   assign wacc_next = (first_tap ? '0 : wacc_q) + {{CW{1'b0}}, in_weight};

   always_comb begin
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      wacc_d  = wacc_q;
      sat_d   = sat_q;
      sum_d   = sum_q;
      wsum_d  = wsum_q;
      osat_d  = osat_q;
      err_d   = 1'b0;
      valid_d = valid_q && !out_ready;
      if (accept) begin
         cnt_d  = last_tap ? '0 : cnt_q + CW'(1);
         acc_d  = acc_next;
         wacc_d = wacc_next;
         sat_d  = sat_next;
         err_d  = (in_last != last_tap);
         // Output registers load only here; accept implies they are free.
         if (last_tap) begin
            sum_d   = acc_next;
            wsum_d  = wacc_next;
            osat_d  = sat_next;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         acc_q   <= '0;
         wacc_q  <= '0;
         sat_q   <= 1'b0;
         sum_q   <= '0;
         wsum_q  <= '0;
         osat_q  <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         wacc_q  <= wacc_d;
         sat_q   <= sat_d;
         sum_q   <= sum_d;
         wsum_q  <= wsum_d;
         osat_q  <= osat_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign out_valid = valid_q;
   assign out_sum   = sum_q;
   assign out_wsum  = wsum_q;
   assign out_sat   = osat_q;
   assign err_last  = err_q;
endmodule

// File: tb/tb_sr_lut_weighted_accum.sv
// Bench for sr_lut_weighted_accum: a 32-bit and a 16-bit accumulator instance share
// the input stimulus; results are compared against a plain-arithmetic pixel model.
module tb_sr_lut_weighted_accum;
   logic clk = 1'b0;
   logic rst_n;
   logic in_valid, in_last, out_ready;
   logic        [7:0] in_weight;
   logic signed [7:0] in_value;

   logic rdy32, ov32, sat32, err32;
   logic signed [31:0] sum32;
   logic        [9:0]  ws32;
   logic rdy16, ov16, sat16, err16;
   logic signed [15:0] sum16;
   logic        [9:0]  ws16;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sr_lut_weighted_accum #(.NTAP(4), .W_WIDTH(8), .V_WIDTH(8), .ACC_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
      .in_weight(in_weight), .in_value(in_value), .in_last(in_last),
      .out_valid(ov32), .out_ready(out_ready), .out_sum(sum32), .out_wsum(ws32),
      .out_sat(sat32), .err_last(err32));

   sr_lut_weighted_accum #(.NTAP(4), .W_WIDTH(8), .V_WIDTH(8), .ACC_WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
      .in_weight(in_weight), .in_value(in_value), .in_last(in_last),
      .out_valid(ov16), .out_ready(out_ready), .out_sum(sum16), .out_wsum(ws16),
      .out_sat(sat16), .err_last(err16));

   // Reference pixel: running sum of w*v, clamped after every tap, sticky clamp flag.
   function automatic void ref_pix(input int w[4], input int v[4], input int aw,
                                   output longint s, output int ws, output bit st);
      longint hi = (longint'(1) <<< (aw - 1)) - 1;
      longint lo = -hi - 1;
      s = 0; ws = 0; st = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s  = s + longint'(w[i]) * longint'(v[i]);
         ws = ws + w[i];
         if (s > hi) begin s = hi; st = 1'b1; end
         else if (s < lo) begin s = lo; st = 1'b1; end
      end
   endfunction

   task automatic drive(input bit vld, input int w, input int v, input bit lst);
      in_valid  = vld;
      in_weight = 8'(w);
      in_value  = 8'(v);
      in_last   = lst;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; out_ready = 1'b1; drive(1'b0, 0, 0, 1'b0);
      repeat (2) @(negedge clk);
      checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ov32); end
      checks++; if (sum32 !== 32'sd0) begin errors++; $display("FAIL reset_sum got=%0d exp=0", sum32); end
      checks++; if (ws32 !== 10'd0) begin errors++; $display("FAIL reset_wsum got=%0d exp=0", ws32); end
      checks++; if (sat32 !== 1'b0 || err32 !== 1'b0) begin errors++; $display("FAIL reset_flags sat=%b err=%b exp=0", sat32, err32); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (rdy32 !== 1'b1 || ov32 !== 1'b0) begin errors++; $display("FAIL reset_ready rdy=%b ov=%b exp 1/0", rdy32, ov32); end
   endtask

   task automatic test_basic();
      int wa[4] = '{1, 2, 3, 4};
      int va[4] = '{10, -20, 30, -40};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, wa[i], va[i], i == 3);
         @(negedge clk);
         checks++; if (err32 !== 1'b0) begin errors++; $display("FAIL basic_err tap=%0d got=%b exp=0", i, err32); end
         if (i < 3) begin
            checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL basic_early_valid tap=%0d got=%b exp=0", i, ov32); end
         end
      end
      drive(1'b0, 0, 0, 1'b0);
      checks++; if (ov32 !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", ov32); end
      checks++; if (longint'(sum32) !== -100) begin errors++; $display("FAIL basic_sum got=%0d exp=-100", sum32); end
      checks++; if (ws32 !== 10'd10) begin errors++; $display("FAIL basic_wsum got=%0d exp=10", ws32); end
      checks++; if (sat32 !== 1'b0) begin errors++; $display("FAIL basic_sat got=%b exp=0", sat32); end
      @(negedge clk);
      checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL basic_clear got=%b exp=0", ov32); end
   endtask

   task automatic test_backpressure();
      int wa[4] = '{1, 2, 3, 4};
      int va[4] = '{10, -20, 30, -40};
      int wr[4], vr[4];
      longint es; int ew; bit est;
      for (int i = 0; i < 4; i++) begin
         wr[i] = int'($urandom_range(255));
         vr[i] = int'($urandom_range(255)) - 128;
      end
      ref_pix(wr, vr, 32, es, ew, est);
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, wa[i], va[i], i == 3);
         @(negedge clk);
      end
      drive(1'b1, wr[0], vr[0], 1'b0);
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++; if (ov32 !== 1'b1 || longint'(sum32) !== -100) begin errors++; $display("FAIL bp_hold cyc=%0d ov=%b sum=%0d exp 1/-100", k, ov32, sum32); end
         checks++; if (rdy32 !== 1'b0) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", k, rdy32); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", rdy32); end
      @(negedge clk);
      checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL bp_drop_valid got=%b exp=0", ov32); end
      for (int i = 1; i < 4; i++) begin
         drive(1'b1, wr[i], vr[i], i == 3);
         @(negedge clk);
      end
      drive(1'b0, 0, 0, 1'b0);
      checks++; if (ov32 !== 1'b1 || longint'(sum32) !== es || int'(ws32) !== ew) begin
         errors++; $display("FAIL bp_next_pixel ov=%b sum=%0d wsum=%0d exp 1/%0d/%0d", ov32, sum32, ws32, es, ew); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      longint s = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 1, i, (i % 4) == 3);
         s = s + i;
         #1;
         checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL b2b_ready tap=%0d got=%b exp=1", i, rdy32); end
         @(negedge clk);
         checks++; if (ov32 !== ((i % 4) == 3)) begin errors++; $display("FAIL b2b_valid tap=%0d got=%b exp=%0d", i, ov32, (i % 4) == 3); end
         if ((i % 4) == 3) begin
            checks++; if (longint'(sum32) !== s || ws32 !== 10'd4) begin errors++; $display("FAIL b2b_sum tap=%0d sum=%0d wsum=%0d exp %0d/4", i, sum32, ws32, s); end
            s = 0;
         end
      end
      drive(1'b0, 0, 0, 1'b0);
      @(negedge clk);
      checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", ov32); end
   endtask

   task automatic test_saturation();
      int wr[4] = '{255, 255, 255, 255};
      int vr[4] = '{127, 127, -128, -128};
      longint es; int ew; bit est;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin drive(1'b1, 255, 127, i == 3); @(negedge clk); end
      drive(1'b0, 0, 0, 1'b0);
      checks++; if (ov16 !== 1'b1 || longint'(sum16) !== 32767) begin errors++; $display("FAIL sat_pos_sum ov=%b got=%0d exp=32767", ov16, sum16); end
      checks++; if (sat16 !== 1'b1) begin errors++; $display("FAIL sat_pos_flag got=%b exp=1", sat16); end
      checks++; if (longint'(sum32) !== 129540 || sat32 !== 1'b0) begin errors++; $display("FAIL sat_wide sum=%0d sat=%b exp 129540/0", sum32, sat32); end
      for (int i = 0; i < 4; i++) begin drive(1'b1, 1, -1, i == 3); @(negedge clk); end
      drive(1'b0, 0, 0, 1'b0);
      checks++; if (longint'(sum16) !== -4 || ws16 !== 10'd4) begin errors++; $display("FAIL sat_next_sum sum=%0d wsum=%0d exp -4/4", sum16, ws16); end
      checks++; if (sat16 !== 1'b0) begin errors++; $display("FAIL sat_next_flag got=%b exp=0", sat16); end
      ref_pix(wr, vr, 16, es, ew, est);
      for (int i = 0; i < 4; i++) begin drive(1'b1, wr[i], vr[i], i == 3); @(negedge clk); end
      drive(1'b0, 0, 0, 1'b0);
      checks++; if (longint'(sum16) !== es || int'(ws16) !== ew || sat16 !== est) begin
         errors++; $display("FAIL sat_recover sum=%0d wsum=%0d sat=%b exp %0d/%0d/%b", sum16, ws16, sat16, es, ew, est); end
      @(negedge clk);
   endtask

   task automatic test_last_err();
      bit lasts[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      int wr[4], vr[4];
      longint es; int ew; bit est;
      for (int i = 0; i < 4; i++) begin
         wr[i] = int'($urandom_range(255));
         vr[i] = int'($urandom_range(255)) - 128;
      end
      ref_pix(wr, vr, 32, es, ew, est);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, wr[i], vr[i], lasts[i]);
         @(negedge clk);
         checks++; if (err32 !== (lasts[i] != (i == 3))) begin errors++; $display("FAIL last_err tap=%0d got=%b exp=%0d", i, err32, lasts[i] != (i == 3)); end
      end
      drive(1'b0, 0, 0, 1'b0);
      checks++; if (ov32 !== 1'b1 || longint'(sum32) !== es) begin errors++; $display("FAIL last_sum ov=%b sum=%0d exp 1/%0d", ov32, sum32, es); end
      @(negedge clk);
      checks++; if (err32 !== 1'b0) begin errors++; $display("FAIL last_err_clear got=%b exp=0", err32); end
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin drive(1'b1, 3, 7, i == 3); @(negedge clk); end
      for (int i = 0; i < 2; i++) begin drive(1'b1, 9, 9, 1'b0); @(negedge clk); end
      drive(1'b0, 0, 0, 1'b0);
      checks++; if (longint'(sum32) !== 84 || ws32 !== 10'd12) begin errors++; $display("FAIL mrst_held sum=%0d wsum=%0d exp 84/12", sum32, ws32); end
      rst_n = 1'b0;
      #1;
      checks++; if (sum32 !== 32'sd0 || ws32 !== 10'd0) begin errors++; $display("FAIL mrst_clear sum=%0d wsum=%0d exp 0/0", sum32, ws32); end
      checks++; if (ov32 !== 1'b0 || sat32 !== 1'b0 || err32 !== 1'b0) begin errors++; $display("FAIL mrst_flags ov=%b sat=%b err=%b exp 0", ov32, sat32, err32); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 2, 5, i == 3);
         @(negedge clk);
         if (i < 3) begin
            checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL mrst_early tap=%0d got=%b exp=0", i, ov32); end
         end
      end
      drive(1'b0, 0, 0, 1'b0);
      checks++; if (ov32 !== 1'b1 || longint'(sum32) !== 40 || ws32 !== 10'd8) begin
         errors++; $display("FAIL mrst_pixel ov=%b sum=%0d wsum=%0d exp 1/40/8", ov32, sum32, ws32); end
      @(negedge clk);
   endtask

   task automatic test_random();
      int npix = 30;
      int cw[4], cv[4];
      int tc = 0, sent = 0, got = 0;
      longint qs[$]; int qw[$]; bit qt[$];
      longint es, psum; int ew; bit est, stall;
      stall = 1'b0; psum = 0;
      for (int cyc = 0; cyc < 3000 && got < npix; cyc++) begin
         checks++; if (err32 !== 1'b0) begin errors++; $display("FAIL rand_err cyc=%0d got=%b exp=0", cyc, err32); end
         if (stall) begin
            checks++; if (ov32 !== 1'b1 || longint'(sum32) !== psum) begin errors++; $display("FAIL rand_stall cyc=%0d ov=%b sum=%0d exp 1/%0d", cyc, ov32, sum32, psum); end
         end
         out_ready = ($urandom_range(3) != 0);
         if (ov32 === 1'b1 && out_ready) begin
            checks++;
            if (qs.size() == 0) begin errors++; $display("FAIL rand_spurious cyc=%0d sum=%0d exp no output", cyc, sum32); end
            else begin
               es = qs.pop_front(); ew = qw.pop_front(); est = qt.pop_front();
               if (longint'(sum32) !== es || int'(ws32) !== ew || sat32 !== est) begin
                  errors++; $display("FAIL rand_pixel n=%0d sum=%0d wsum=%0d sat=%b exp %0d/%0d/%b", got, sum32, ws32, sat32, es, ew, est); end
            end
            got++;
         end
         stall = (ov32 === 1'b1) && !out_ready;
         psum  = longint'(sum32);
         if (sent < npix * 4 && $urandom_range(3) != 0) begin
            cw[tc] = int'($urandom_range(255));
            cv[tc] = int'($urandom_range(255)) - 128;
            drive(1'b1, cw[tc], cv[tc], tc == 3);
         end else begin
            drive(1'b0, 0, 0, 1'b0);
         end
         #1;
         if (in_valid && rdy32) begin
            sent++;
            if (tc == 3) begin
               ref_pix(cw, cv, 32, es, ew, est);
               qs.push_back(es); qw.push_back(ew); qt.push_back(est);
               tc = 0;
            end else begin
               tc++;
            end
         end
         @(negedge clk);
      end
      checks++; if (got !== npix) begin errors++; $display("FAIL rand_timeout pixels=%0d exp=%0d", got, npix); end
      drive(1'b0, 0, 0, 1'b0);
      out_ready = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_saturation();
      test_last_err();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end
endmodule
